// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared BCD-to-segment decoder is fed one digit at a time on bcd_out while
// the matching active-low anode is pulled low. Between digits, every anode is
// held off for a guard interval to suppress ghosting. New display values arrive
// over a valid/ready handshake. They are staged and only committed at a frame
// boundary, or immediately while the display is off, so a frame never shows a
// mix of old and new digits.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable (0 = display dark)
//   blank_lz    1 = blank leading zeros (digit 0 is never blanked)
//   load_valid  load_data is valid
//   load_ready  controller can accept load_data (no value staged)
//   load_data   packed BCD, digit 0 (rightmost) in bits [3:0]
//   bcd_out     BCD code for the shared decoder, 4'hF = blank
//   anode       active-low digit enables, at most one bit low
//   frame_done  one-cycle pulse after the last digit's dwell ends
// -----------------------------------------------------------------------------
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    // One counter serves both dwell intervals, so it is sized for the longer one.
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    frame_done_q, frame_done_d;

    // Set by the next-state logic on the SHOW(last digit) -> GUARD edge.
    logic                    frame_end;

    // -------------------------------------------------------------------------
    // Leading-zero blanking. upper_zero[i] is 1 when digits i..NUM_DIGITS-1 of
    // the committed value are all zero. Digit 0 is never blanked, so it needs
    // no entry.
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS:1] upper_zero;
    logic [3:0]          digit_disp [NUM_DIGITS];

    assign upper_zero[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign digit_disp[gi] = disp_q[3:0];
        end else begin : g_upper
            if (gi < NUM_DIGITS) begin : g_run
                assign upper_zero[gi] = (disp_q[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
            end
            assign digit_disp[gi] = (blank_lz && upper_zero[gi]) ? 4'hF : disp_q[4*gi +: 4];
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            anode_q      <= '1;
            bcd_q        <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            anode_q      <= anode_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: scan FSM, dwell counter, digit index, load staging
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        frame_end    = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                idx_d = '0;
                cnt_d = '0;
                if (en) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (!en) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d   = ST_GUARD;
                    cnt_d     = '0;
                    frame_end = (idx_q == IDX_LAST);
                    idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // A transfer needs pend_valid_q=0 and a commit needs pend_valid_q=1,
        // so the two can never coincide.
        if (pend_valid_q && ((state_q == ST_OFF) || frame_end)) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end
        if (load_valid && !pend_valid_q) begin
            pend_d       = load_data;
            pend_valid_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. It is computed from the next state, so anode and bcd_out
    // update together on the edge that enters SHOW. There is never a cycle
    // with an anode low and a stale code.
    // -------------------------------------------------------------------------
    always_comb begin
        anode_d      = '1;
        bcd_d        = 4'hF;
        frame_done_d = frame_end;
        if (state_d == ST_SHOW) begin
            anode_d[idx_d] = 1'b0;
            bcd_d          = digit_disp[idx_d];
        end
    end

    assign anode      = anode_q;
    assign bcd_out    = bcd_q;
    assign frame_done = frame_done_q;
    assign load_ready = ~pend_valid_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// Testbench for seg_scan_controller (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2).
// A timeline model tracks the cycles elapsed since the scan was enabled. From
// that count it derives the digit slot and the guard or show phase with plain
// arithmetic, and it keeps the staged and committed display values. Every
// output is compared with this model after every clock edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int GC    = 2;
    localparam int SLOT  = RD + GC;
    localparam int FRAME = ND * SLOT;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          en         = 1'b0;
    logic          blank_lz   = 1'b0;
    logic          load_valid = 1'b0;
    logic [15:0]   load_data  = '0;
    logic          load_ready;
    logic [3:0]    bcd_out;
    logic [ND-1:0] anode;
    logic          frame_done;

    seg_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .blank_lz  (blank_lz),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .bcd_out   (bcd_out),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_run;   // scanning (not OFF)
    int          m_t;     // cycles since the scan entered its first guard
    bit          m_pv;    // value staged
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    bit          m_fd;
    bit          m_blz;
    int          fd_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_digit(input int i, input logic [15:0] v, input bit blz);
        logic [15:0] upper;
        upper = v >> (4 * i);
        if (blz && i > 0 && upper == 16'h0)
            return 4'hF;
        return upper[3:0];
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_t    = 0;
        m_pv   = 1'b0;
        m_pend = '0;
        m_disp = '0;
        m_fd   = 1'b0;
        m_blz  = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [3:0] ea;
        logic [3:0] eb;
        int         s;
        ea = 4'hF;
        eb = 4'hF;
        if (m_run) begin
            s = m_t % FRAME;
            if ((s % SLOT) >= GC) begin
                ea = ~(4'b0001 << (s / SLOT));
                eb = exp_digit(s / SLOT, m_disp, m_blz);
            end
        end
        check("anode", 32'(anode), 32'(ea));
        check("bcd_out", 32'(bcd_out), 32'(eb));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("load_ready", 32'(load_ready), 32'(!m_pv));
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare 1 time unit later.
    task automatic step();
        bit fe;
        bit commit;
        bit xfer;
        @(posedge clk);
        fe     = m_run && en && ((m_t % FRAME) == FRAME - 1);
        commit = m_pv && (!m_run || fe);
        xfer   = load_valid && !m_pv;
        if (m_run) begin
            if (!en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end else if (en) begin
            m_run = 1'b1;
            m_t   = 0;
        end
        if (commit) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (xfer) begin
            m_pend = load_data;
            m_pv   = 1'b1;
            $display("load accepted data=%h at t=%0t", load_data, $time);
        end
        m_fd  = fe;
        m_blz = blank_lz;
        #1;
        compare_outputs();
        if (frame_done === 1'b1)
            fd_count++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    // Advance until the model is in the second SHOW cycle of digit d, with a bound.
    task automatic run_to_digit(input int d);
        int n;
        n = 0;
        while (!(m_run && (m_t % FRAME) == d * SLOT + GC + 1) && n < 3 * FRAME) begin
            step();
            n++;
        end
        if (n >= 3 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL wait_digit%0d got=timeout exp=reached", d);
        end
    endtask

    task automatic load_once(input logic [15:0] v);
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        #1;
        compare_outputs();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        fd_count = 0;
        #1 rst_n = 1'b0;
        #1 compare_outputs();
        #10 rst_n = 1'b1;

        // Free-running scan of the reset value: two frames plus the entry edge.
        en = 1'b1;
        fd_count = 0;
        steps(2 * FRAME + 1);
        check("frame_done_count", 32'(fd_count), 32'd2);

        // Load while off: one cycle not ready, then commit and scan 1234.
        en = 1'b0;
        steps(2);
        load_once(16'h1234);
        step();
        en = 1'b1;
        steps(FRAME + 3);

        // Mid-frame load, with a second value held valid during the wait.
        run_to_digit(1);
        load_once(16'h5678);
        load_valid = 1'b1;
        load_data  = 16'h4321;
        steps(FRAME + SLOT);
        load_valid = 1'b0;
        steps(2 * FRAME);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load_once(16'h0070);
        steps(2 * FRAME);
        load_once(16'h0000);
        steps(2 * FRAME);
        blank_lz = 1'b0;
        steps(FRAME);

        // Drop the enable during digit 2, then re-enable.
        run_to_digit(2);
        en = 1'b0;
        steps(2);
        en = 1'b1;
        steps(FRAME);

        // Asynchronous reset during SHOW.
        run_to_digit(1);
        async_reset();
        steps(FRAME + 2);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            for (int k = 0; k < ND; k++)
                v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            en         = ($urandom_range(0, 99) < 97);
            load_valid = ($urandom_range(0, 99) < 20);
            load_data  = v;
            if ($urandom_range(0, 99) < 5)
                blank_lz = ~blank_lz;
            step();
        end
        load_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
